// File: rtl/alu_control_sequencer_if.sv
// Control bundle between the hardwired sequencer (master) and the multi-cycle datapath (slave).
// The sequencer reads run/mem_ready/ir and drives every datapath strobe.
interface alu_control_sequencer_if #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 16
);
  logic              run;
  logic              mem_ready;
  logic [DATA_W-1:0] ir;

  logic              pc_out;
  logic              mar_in;
  logic              inc_pc;
  logic              read;
  logic              mdr_in;
  logic              mdr_out;
  logic              ir_in;
  logic              y_in;
  logic              z_in;
  logic              z_low_out;
  logic              z_high_out;
  logic              hi_in;
  logic              lo_in;
  logic [NREGS-1:0]  reg_in;
  logic [NREGS-1:0]  reg_out;
  logic [4:0]        alu_op;
  logic              done;
  logic              illegal;
  logic              halted;

  modport master (
    input  run, mem_ready, ir,
    output pc_out, mar_in, inc_pc, read, mdr_in, mdr_out, ir_in,
           y_in, z_in, z_low_out, z_high_out, hi_in, lo_in,
           reg_in, reg_out, alu_op, done, illegal, halted
  );

  modport slave (
    output run, mem_ready, ir,
    input  pc_out, mar_in, inc_pc, read, mdr_in, mdr_out, ir_in,
           y_in, z_in, z_low_out, z_high_out, hi_in, lo_in,
           reg_in, reg_out, alu_op, done, illegal, halted
  );
endinterface

// File: rtl/alu_control_sequencer.sv
// Hardwired fetch/decode/execute sequencer: Moore FSM emitting one-hot datapath strobes
// from (state, ir) for binary, wide (mul/div), unary, NOP, HALT and illegal opcodes.
module alu_control_sequencer #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 16
) (
  input  logic                    clock,
  input  logic                    clear,
  alu_control_sequencer_if.master bus
);

  localparam int REG_W = $clog2(NREGS);
  localparam int LOW_W = DATA_W - 5 - 3*REG_W;

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_T0   = 4'd1;
  localparam logic [3:0] S_T1   = 4'd2;
  localparam logic [3:0] S_T2   = 4'd3;
  localparam logic [3:0] S_T3   = 4'd4;
  localparam logic [3:0] S_T4   = 4'd5;
  localparam logic [3:0] S_T5   = 4'd6;
  localparam logic [3:0] S_T6   = 4'd7;
  localparam logic [3:0] S_HALT = 4'd8;

  logic [3:0]       r_state;
  logic [3:0]       w_nextState;
  logic [3:0]       w_afterLast;
  logic [4:0]       w_op;
  logic [REG_W-1:0] w_ra;
  logic [REG_W-1:0] w_rb;
  logic [REG_W-1:0] w_rc;
  logic             w_isBin;
  logic             w_isWide;
  logic             w_isUn;
  logic             w_isNop;
  logic             w_isHalt;
  logic             w_isIll;

  assign w_op = bus.ir[DATA_W-1 -: 5];
  assign w_ra = bus.ir[DATA_W-6 -: REG_W];
  assign w_rb = bus.ir[DATA_W-6-REG_W -: REG_W];
  assign w_rc = bus.ir[DATA_W-6-2*REG_W -: REG_W];

  generate
    if (LOW_W > 0) begin : g_lowBits
      logic w_unused;
      assign w_unused = &{1'b0, bus.ir[LOW_W-1:0]};
    end
  endgenerate

  assign w_isBin  = (w_op <= 5'd8);
  assign w_isWide = (w_op == 5'd15) || (w_op == 5'd16);
  assign w_isUn   = (w_op == 5'd17) || (w_op == 5'd18);
  assign w_isNop  = (w_op == 5'd26);
  assign w_isHalt = (w_op == 5'd27);
  assign w_isIll  = !(w_isBin || w_isWide || w_isUn || w_isNop || w_isHalt);

  // run is only consulted here, in IDLE and in whichever state is the last step
  assign w_afterLast = bus.run ? S_T0 : S_IDLE;

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE: if (bus.run) w_nextState = S_T0;
      S_T0:   w_nextState = S_T1;
      S_T1:   if (bus.mem_ready) w_nextState = S_T2;
      S_T2:   w_nextState = S_T3;
      S_T3: begin
        if (w_isHalt)                w_nextState = S_HALT;
        else if (w_isNop || w_isIll) w_nextState = w_afterLast;
        else                         w_nextState = S_T4;
      end
      S_T4:   w_nextState = S_T5;
      S_T5:   w_nextState = w_isWide ? S_T6 : w_afterLast;
      S_T6:   w_nextState = w_afterLast;
      S_HALT: w_nextState = S_HALT;
      default: w_nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) r_state <= S_IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    bus.pc_out     = 1'b0;
    bus.mar_in     = 1'b0;
    bus.inc_pc     = 1'b0;
    bus.read       = 1'b0;
    bus.mdr_in     = 1'b0;
    bus.mdr_out    = 1'b0;
    bus.ir_in      = 1'b0;
    bus.y_in       = 1'b0;
    bus.z_in       = 1'b0;
    bus.z_low_out  = 1'b0;
    bus.z_high_out = 1'b0;
    bus.hi_in      = 1'b0;
    bus.lo_in      = 1'b0;
    bus.reg_in     = '0;
    bus.reg_out    = '0;
    bus.alu_op     = 5'd0;
    bus.done       = 1'b0;
    bus.illegal    = 1'b0;
    bus.halted     = 1'b0;
    case (r_state)
      S_T0: begin
        bus.pc_out = 1'b1;
        bus.mar_in = 1'b1;
        bus.inc_pc = 1'b1;
      end
      S_T1: begin
        bus.read   = 1'b1;
        bus.mdr_in = 1'b1;
      end
      S_T2: begin
        bus.mdr_out = 1'b1;
        bus.ir_in   = 1'b1;
      end
      S_T3: begin
        if (w_isBin || w_isWide || w_isUn) begin
          bus.reg_out = NREGS'(1) << w_rb;
          bus.y_in    = 1'b1;
        end
        bus.done    = w_isNop || w_isIll;
        bus.illegal = w_isIll;
      end
      // unary ops take their only operand from Y, so no register drives the bus here
      S_T4: begin
        if (w_isBin || w_isWide) bus.reg_out = NREGS'(1) << w_rc;
        bus.alu_op = w_op;
        bus.z_in   = 1'b1;
      end
      S_T5: begin
        bus.z_low_out = 1'b1;
        if (w_isWide) begin
          bus.lo_in = 1'b1;
        end else begin
          bus.reg_in = NREGS'(1) << w_ra;
          bus.done   = 1'b1;
        end
      end
      S_T6: begin
        bus.z_high_out = 1'b1;
        bus.hi_in      = 1'b1;
        bus.done       = 1'b1;
      end
      S_HALT: bus.halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_control_sequencer.sv
// Randomized self-checking bench: an instruction-level model lists the expected strobe
// vector for every cycle of each instruction and the DUT is compared cycle by cycle.
module tb_alu_control_sequencer;

  localparam logic [12:0] PC_OUT  = 13'h1000;
  localparam logic [12:0] MAR_IN  = 13'h0800;
  localparam logic [12:0] INC_PC  = 13'h0400;
  localparam logic [12:0] READ    = 13'h0200;
  localparam logic [12:0] MDR_IN  = 13'h0100;
  localparam logic [12:0] MDR_OUT = 13'h0080;
  localparam logic [12:0] IR_IN   = 13'h0040;
  localparam logic [12:0] Y_IN    = 13'h0020;
  localparam logic [12:0] Z_IN    = 13'h0010;
  localparam logic [12:0] Z_LOW   = 13'h0008;
  localparam logic [12:0] Z_HIGH  = 13'h0004;
  localparam logic [12:0] HI_IN   = 13'h0002;
  localparam logic [12:0] LO_IN   = 13'h0001;
  localparam int          DONE_BIT = 39;

  localparam int C_BIN = 0, C_WIDE = 1, C_UN = 2, C_NOP = 3, C_HALT = 4, C_ILL = 5;

  typedef struct {
    logic [63:0] exp;
    logic        mr;
  } step_t;

  logic        clock = 1'b0;
  logic        clear;
  logic [63:0] obsVec;
  int          checks = 0;
  int          errors = 0;

  alu_control_sequencer_if #(.DATA_W(32), .NREGS(16)) bus ();

  alu_control_sequencer #(.DATA_W(32), .NREGS(16)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus.master)
  );

  always #5 clock = ~clock;

  assign obsVec = {11'd0,
                   bus.pc_out, bus.mar_in, bus.inc_pc, bus.read, bus.mdr_in, bus.mdr_out,
                   bus.ir_in, bus.y_in, bus.z_in, bus.z_low_out, bus.z_high_out, bus.hi_in,
                   bus.lo_in, bus.done, bus.illegal, bus.halted, bus.alu_op,
                   bus.reg_in, bus.reg_out};

  function automatic logic [63:0] vec(logic [12:0] s, logic d, logic il, logic h,
                                      logic [4:0] a, logic [15:0] ri, logic [15:0] ro);
    return {11'd0, s, d, il, h, a, ri, ro};
  endfunction

  function automatic int opClass(logic [4:0] op);
    if (op <= 5'd8)                     return C_BIN;
    if (op == 5'd15 || op == 5'd16)     return C_WIDE;
    if (op == 5'd17 || op == 5'd18)     return C_UN;
    if (op == 5'd26)                    return C_NOP;
    if (op == 5'd27)                    return C_HALT;
    return C_ILL;
  endfunction

  function automatic int latency(int cls);
    case (cls)
      C_NOP, C_ILL: return 4;
      C_WIDE:       return 7;
      default:      return 6;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Entered #1 after the edge that moved the DUT into T0; leaves #1 after the edge ending the last step.
  task automatic applyStimulus(input logic [31:0] instr, input int memWait, input bit dropRun, input int clearAt);
    step_t       q[$];
    step_t       s;
    logic [4:0]  op;
    logic [15:0] ra, rb, rc;
    int          cls;
    int          doneAt;
    op  = instr[31:27];
    ra  = 16'd1 << instr[26:23];
    rb  = 16'd1 << instr[22:19];
    rc  = 16'd1 << instr[18:15];
    cls = opClass(op);
    bus.ir = instr;

    s.mr = 1'b0;
    s.exp = vec(PC_OUT | MAR_IN | INC_PC, 0, 0, 0, 0, 0, 0); q.push_back(s);
    for (int i = 0; i <= memWait; i++) begin
      s.exp = vec(READ | MDR_IN, 0, 0, 0, 0, 0, 0);
      s.mr  = (i == memWait);
      q.push_back(s);
    end
    s.mr = 1'b0;
    s.exp = vec(MDR_OUT | IR_IN, 0, 0, 0, 0, 0, 0); q.push_back(s);
    case (cls)
      C_NOP:  begin s.exp = vec(0, 1, 0, 0, 0, 0, 0); q.push_back(s); end
      C_ILL:  begin s.exp = vec(0, 1, 1, 0, 0, 0, 0); q.push_back(s); end
      C_HALT: begin
        s.exp = vec(0, 0, 0, 0, 0, 0, 0); q.push_back(s);
        for (int i = 0; i < 4; i++) begin
          s.exp = vec(0, 0, 0, 1, 0, 0, 0); q.push_back(s);
        end
      end
      default: begin
        s.exp = vec(Y_IN, 0, 0, 0, 0, 0, rb); q.push_back(s);
        s.exp = vec(Z_IN, 0, 0, 0, op, 0, (cls == C_UN) ? 16'd0 : rc); q.push_back(s);
        if (cls == C_WIDE) begin
          s.exp = vec(Z_LOW | LO_IN, 0, 0, 0, 0, 0, 0); q.push_back(s);
          s.exp = vec(Z_HIGH | HI_IN, 1, 0, 0, 0, 0, 0); q.push_back(s);
        end else begin
          s.exp = vec(Z_LOW, 1, 0, 0, 0, ra, 0); q.push_back(s);
        end
      end
    endcase

    doneAt = -1;
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clock);
      checkOutput($sformatf("ir%08h c%0d", instr, i), obsVec, q[i].exp);
      if (obsVec[DONE_BIT] && doneAt < 0) doneAt = i + 1;
      if (i == clearAt) begin
        clear = 1'b1;
        #1 checkOutput("clearAsync", obsVec, 64'd0);
        return;
      end
      bus.mem_ready = (q[i].mr) ? 1'b1 : ((cls == C_HALT || i > memWait + 1) ? 1'($urandom_range(0, 1)) : 1'b0);
      if (q[i].mr) bus.mem_ready = 1'b1;
      if (dropRun && i == 2) bus.run = 1'b0;
      @(posedge clock);
      #1;
    end
    if (cls != C_HALT)
      checkOutput($sformatf("latency ir%08h", instr), 64'(doneAt), 64'(latency(cls) + memWait));
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL timeout: got no finish expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [31:0] instr;
    logic [4:0]  op;
    clear = 1'b1;
    bus.run = 1'b0;
    bus.mem_ready = 1'b0;
    bus.ir = 32'd0;
    #1 checkOutput("reset", obsVec, 64'd0);
    repeat (2) @(posedge clock);
    #1 clear = 1'b0;
    @(negedge clock) checkOutput("idleNoRun", obsVec, 64'd0);
    @(posedge clock);
    #1 checkOutput("idleStill", obsVec, 64'd0);

    bus.run = 1'b1;
    @(posedge clock);
    #1;
    applyStimulus(32'h8A800000, 0, 1'b0, -1);
    applyStimulus(32'h01890000, 0, 1'b0, -1);
    applyStimulus(32'h78338000, 0, 1'b0, -1);
    applyStimulus(32'h01890000, 3, 1'b0, -1);
    applyStimulus(32'hF8000000, 0, 1'b0, -1);
    applyStimulus(32'hD0000000, 1, 1'b0, -1);

    for (int n = 0; n < 40; n++) begin
      op = 5'($urandom_range(0, 31));
      if (op == 5'd27) op = 5'd16;
      instr = {op, 27'($urandom)};
      applyStimulus(instr, int'($urandom_range(0, 3)), 1'b0, -1);
    end

    applyStimulus(32'h10C48000, 0, 1'b1, -1);
    @(negedge clock) checkOutput("idleAfterDrop", obsVec, 64'd0);
    @(posedge clock);
    #1 checkOutput("idleAfterDrop2", obsVec, 64'd0);

    bus.run = 1'b1;
    @(posedge clock);
    #1;
    applyStimulus(32'h01890000, 0, 1'b0, 4);
    bus.run = 1'b0;
    @(posedge clock);
    #1 clear = 1'b0;
    @(negedge clock) checkOutput("idleAfterClear", obsVec, 64'd0);

    bus.run = 1'b1;
    @(posedge clock);
    #1;
    applyStimulus(32'hD8000000, 0, 1'b0, -1);
    clear = 1'b1;
    #1 checkOutput("haltClear", obsVec, 64'd0);
    bus.run = 1'b0;
    @(posedge clock);
    #1 clear = 1'b0;
    @(negedge clock) checkOutput("idleAfterHalt", obsVec, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
